alu_param: RTL and testbench

Parametrised RV32/RV64 integer ALU for the kianv multicycle core. It computes add/sub, logic, compare, branch-condition, LUI/AUIPC and shift results for the control unit. Shifts are multi-bit-per-cycle iterative with a configurable step, and the block keeps the valid/ready handshake the control FSM already uses. It replaces the fixed 32-bit, 1-bit-per-cycle ALU in the execute stage.

---
 rtl/alu_param_pkg.sv | 38 +++
 rtl/alu_param_if.sv | 26 ++
 rtl/alu_shift_seq.sv | 77 +++++++
 rtl/alu_param.sv | 127 ++++++++++++
 tb/tb_alu_param.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_param_pkg.sv
// alu_param shared definitions: ALU operation codes and shift FSM encodings.
// Optional build macro: ALU_BARREL_SHIFT_EN (see alu_param.sv).
package alu_param_pkg;

  localparam int ALU_CTRL_WIDTH = 5;

  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_ADD   = 5'd0;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_SUB   = 5'd1;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_AND   = 5'd2;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_OR    = 5'd3;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_XOR   = 5'd4;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_SLT   = 5'd5;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_SLTU  = 5'd6;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_SLL   = 5'd7;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_SRL   = 5'd8;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_SRA   = 5'd9;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_LUI   = 5'd10;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_AUIPC = 5'd11;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_BEQ   = 5'd12;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_BNE   = 5'd13;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_BLT   = 5'd14;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_BGE   = 5'd15;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_BLTU  = 5'd16;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_BGEU  = 5'd17;

  typedef enum logic [1:0] {
    SH_IDLE,
    SH_SHIFT,
    SH_DONE
  } sh_state_e;

  typedef enum logic [1:0] {
    SH_SLL,
    SH_SRL,
    SH_SRA
  } sh_mode_e;

endpackage

// File: rtl/alu_param_if.sv
// ALU request/result bundle between the control unit (master)
// and the ALU (slave).
interface alu_param_if #(
  parameter int XLEN = 32
);
  import alu_param_pkg::*;

  logic [XLEN-1:0]           a;
  logic [XLEN-1:0]           b;
  logic [ALU_CTRL_WIDTH-1:0] alucontrol;
  logic                      alu_valid;
  logic                      alu_ready;
  logic [XLEN-1:0]           result;
  logic                      zero;
  logic                      busy;

  modport master (
    output a, b, alucontrol, alu_valid,
    input  alu_ready, result, zero, busy
  );

  modport slave (
    input  a, b, alucontrol, alu_valid,
    output alu_ready, result, zero, busy
  );
endinterface

// File: rtl/alu_shift_seq.sv
// Iterative shifter: up to SHIFT_STEP bits per cycle,
// IDLE -> SHIFT -> DONE, aborted whenever valid drops.
module alu_shift_seq
  import alu_param_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1,
  localparam int SHW       = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [XLEN-1:0] a,
  input  logic [SHW-1:0]  shamt,
  input  sh_mode_e        mode,
  input  logic            start,
  input  logic            valid,
  output logic [XLEN-1:0] shreg,
  output logic            done,
  output logic            busy
);

  localparam logic [SHW:0] STEP_W = (SHW+1)'(SHIFT_STEP);

  sh_state_e       state_q, state_d;
  logic [XLEN-1:0] shreg_q, shreg_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [SHW:0]    k;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    // k never exceeds cnt, so it always fits back into cnt's width
    k = ({1'b0, cnt_q} > STEP_W) ? STEP_W : {1'b0, cnt_q};
    case (state_q)
      SH_IDLE: begin
        if (start) begin
          shreg_d = a;
          cnt_d   = shamt;
          state_d = (shamt == '0) ? SH_DONE : SH_SHIFT;
        end
      end
      SH_SHIFT: begin
        if (!valid) begin
          state_d = SH_IDLE;
        end else begin
          case (mode)
            SH_SRA:  shreg_d = $signed(shreg_q) >>> k;
            SH_SRL:  shreg_d = shreg_q >> k;
            default: shreg_d = shreg_q << k;
          endcase
          cnt_d = cnt_q - k[SHW-1:0];
          if (cnt_d == '0) state_d = SH_DONE;
        end
      end
      SH_DONE: state_d = SH_IDLE;
      default: state_d = SH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= SH_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign shreg = shreg_q;
  assign done  = (state_q == SH_DONE);
  assign busy  = (state_q != SH_IDLE);

endmodule

// File: rtl/alu_param.sv
// RV32/RV64 integer ALU with iterative shifter.
// Define ALU_BARREL_SHIFT_EN for single-cycle barrel shifts instead.
module alu_param
  import alu_param_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input logic        clk,
  input logic        resetn,
  alu_param_if.slave bus
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0]           a, b;
  logic [ALU_CTRL_WIDTH-1:0] ctrl;
  logic                      valid;
  logic                      is_sub, is_shift;
  logic [XLEN:0]             sum;
  logic                      ltu, lt, eq;
  sh_mode_e                  mode;
  logic [XLEN-1:0]           sh_res;
  logic                      sh_ready, sh_busy;
  logic [XLEN-1:0]           res;
  logic                      rdy;

  assign a     = bus.a;
  assign b     = bus.b;
  assign ctrl  = bus.alucontrol;
  assign valid = bus.alu_valid;

  assign is_sub = ctrl inside {
    ALU_CTRL_SUB, ALU_CTRL_SLT, ALU_CTRL_SLTU,
    ALU_CTRL_BEQ, ALU_CTRL_BNE, ALU_CTRL_BLT,
    ALU_CTRL_BGE, ALU_CTRL_BLTU, ALU_CTRL_BGEU
  };
  assign is_shift = ctrl inside {
    ALU_CTRL_SLL, ALU_CTRL_SRL, ALU_CTRL_SRA
  };

  // Bit XLEN of the subtract is set exactly when a < b unsigned
  assign sum = (is_sub ? {1'b1, ~b} : {1'b0, b})
             + {1'b0, a} + {{XLEN{1'b0}}, is_sub};
  assign ltu = sum[XLEN];
  assign lt  = (a[XLEN-1] != b[XLEN-1]) ? a[XLEN-1] : sum[XLEN];
  assign eq  = (sum[XLEN-1:0] == '0);

  always_comb begin
    case (ctrl)
      ALU_CTRL_SRA: mode = SH_SRA;
      ALU_CTRL_SRL: mode = SH_SRL;
      default:      mode = SH_SLL;
    endcase
  end

`ifdef ALU_BARREL_SHIFT_EN
  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  always_comb begin
    case (mode)
      SH_SRA:  sh_res = $signed(a) >>> shamt;
      SH_SRL:  sh_res = a >> shamt;
      default: sh_res = a << shamt;
    endcase
  end

  assign sh_ready = valid;
  assign sh_busy  = 1'b0;
`else
  logic sh_done;

  alu_shift_seq #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shift_seq (
    .clk    (clk),
    .resetn (resetn),
    .a      (a),
    .shamt  (b[SHW-1:0]),
    .mode   (mode),
    .start  (valid && is_shift),
    .valid  (valid),
    .shreg  (sh_res),
    .done   (sh_done),
    .busy   (sh_busy)
  );

  assign sh_ready = sh_done && valid;
`endif

  always_comb begin
    res = '0;
    rdy = valid;
    case (ctrl)
      ALU_CTRL_ADD,
      ALU_CTRL_SUB,
      ALU_CTRL_AUIPC: res = sum[XLEN-1:0];
      ALU_CTRL_AND:   res = a & b;
      ALU_CTRL_OR:    res = a | b;
      ALU_CTRL_XOR:   res = a ^ b;
      ALU_CTRL_SLT:   res = {{(XLEN-1){1'b0}}, lt};
      ALU_CTRL_SLTU:  res = {{(XLEN-1){1'b0}}, ltu};
      ALU_CTRL_BEQ:   res = {{(XLEN-1){1'b0}}, eq};
      ALU_CTRL_BNE:   res = {{(XLEN-1){1'b0}}, !eq};
      ALU_CTRL_BLT:   res = {{(XLEN-1){1'b0}}, lt};
      ALU_CTRL_BGE:   res = {{(XLEN-1){1'b0}}, !lt};
      ALU_CTRL_BLTU:  res = {{(XLEN-1){1'b0}}, ltu};
      ALU_CTRL_BGEU:  res = {{(XLEN-1){1'b0}}, !ltu};
      ALU_CTRL_LUI:   res = b;
      ALU_CTRL_SLL,
      ALU_CTRL_SRL,
      ALU_CTRL_SRA: begin
        res = sh_res;
        rdy = sh_ready;
      end
      default:        res = '0;
    endcase
  end

  assign bus.result    = res;
  assign bus.alu_ready = rdy;
  assign bus.zero      = (res == '0);
  assign bus.busy      = sh_busy;

endmodule

// File: tb/tb_alu_param.sv
// Self-checking bench for alu_param: three configurations
// (32/step4, 64/step1, 32/step8) share one stimulus bus.
module tb_alu_param;
  import alu_param_pkg::*;

`ifdef ALU_BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [63:0] a_s, b_s;
  logic [4:0]  ctrl_s;
  logic        valid_s;

  alu_param_if #(.XLEN(32)) if_a ();
  alu_param_if #(.XLEN(64)) if_b ();
  alu_param_if #(.XLEN(32)) if_c ();

  assign if_a.a = a_s[31:0];
  assign if_a.b = b_s[31:0];
  assign if_a.alucontrol = ctrl_s;
  assign if_a.alu_valid = valid_s;
  assign if_b.a = a_s;
  assign if_b.b = b_s;
  assign if_b.alucontrol = ctrl_s;
  assign if_b.alu_valid = valid_s;
  assign if_c.a = a_s[31:0];
  assign if_c.b = b_s[31:0];
  assign if_c.alucontrol = ctrl_s;
  assign if_c.alu_valid = valid_s;

  alu_param #(.XLEN(32), .SHIFT_STEP(4)) dut_a (
    .clk(clk), .resetn(resetn), .bus(if_a.slave));
  alu_param #(.XLEN(64), .SHIFT_STEP(1)) dut_b (
    .clk(clk), .resetn(resetn), .bus(if_b.slave));
  alu_param #(.XLEN(32), .SHIFT_STEP(8)) dut_c (
    .clk(clk), .resetn(resetn), .bus(if_c.slave));

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int          w;
    logic [4:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t tv[$];

  function automatic int dut_xlen(int w);
    return (w == 1) ? 64 : 32;
  endfunction

  function automatic int dut_step(int w);
    return (w == 0) ? 4 : ((w == 1) ? 1 : 8);
  endfunction

  task automatic chk(string name, logic [63:0] got,
                     logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  name, got, exp);
  endtask

  task automatic sample(input int w, output logic [63:0] r,
                        output logic rdy, output logic z,
                        output logic bsy);
    case (w)
      0: begin
        r = {32'b0, if_a.result}; rdy = if_a.alu_ready;
        z = if_a.zero; bsy = if_a.busy;
      end
      1: begin
        r = if_b.result; rdy = if_b.alu_ready;
        z = if_b.zero; bsy = if_b.busy;
      end
      default: begin
        r = {32'b0, if_c.result}; rdy = if_c.alu_ready;
        z = if_c.zero; bsy = if_c.busy;
      end
    endcase
  endtask

  // Reference: plain integer arithmetic on masked 64-bit values
  function automatic logic [63:0] ref_alu(int xlen,
      logic [4:0] op, logic [63:0] a, logic [63:0] b);
    logic [63:0] m, ua, ub;
    longint sa, sb;
    int amt;
    m  = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                      : 64'h0000_0000_FFFF_FFFF;
    ua = a & m;
    ub = b & m;
    sa = (xlen == 64) ? $signed(ua) : longint'($signed(ua[31:0]));
    sb = (xlen == 64) ? $signed(ub) : longint'($signed(ub[31:0]));
    amt = int'(b[5:0]) % xlen;
    case (op)
      ALU_CTRL_ADD, ALU_CTRL_AUIPC: return (ua + ub) & m;
      ALU_CTRL_SUB:  return (ua - ub) & m;
      ALU_CTRL_AND:  return ua & ub;
      ALU_CTRL_OR:   return ua | ub;
      ALU_CTRL_XOR:  return ua ^ ub;
      ALU_CTRL_SLT:  return 64'(sa < sb);
      ALU_CTRL_SLTU: return 64'(ua < ub);
      ALU_CTRL_BEQ:  return 64'(ua == ub);
      ALU_CTRL_BNE:  return 64'(ua != ub);
      ALU_CTRL_BLT:  return 64'(sa < sb);
      ALU_CTRL_BGE:  return 64'(sa >= sb);
      ALU_CTRL_BLTU: return 64'(ua < ub);
      ALU_CTRL_BGEU: return 64'(ua >= ub);
      ALU_CTRL_LUI:  return ub;
      ALU_CTRL_SLL:  return (ua << amt) & m;
      ALU_CTRL_SRL:  return ua >> amt;
      ALU_CTRL_SRA:  return 64'(sa >>> amt) & m;
      default:       return 64'h0;
    endcase
  endfunction

  function automatic int ref_lat(int xlen, int step,
                                 logic [63:0] b);
    int amt;
    amt = int'(b[5:0]) % xlen;
    if (BARREL) return 0;
    return 1 + (amt + step - 1) / step;
  endfunction

  function automatic bit is_shift(logic [4:0] op);
    return op == ALU_CTRL_SLL || op == ALU_CTRL_SRL ||
           op == ALU_CTRL_SRA;
  endfunction

  task automatic ns_check(input int w, input logic [4:0] op,
      input logic [63:0] a, input logic [63:0] b,
      input logic [63:0] exp, input string name);
    logic [63:0] r;
    logic rdy, z, bsy;
    @(negedge clk);
    a_s = a; b_s = b; ctrl_s = op; valid_s = 1'b1;
    #1;
    sample(w, r, rdy, z, bsy);
    chk({name, " result"}, r, exp);
    chk({name, " ready"}, 64'(rdy), 64'd1);
    chk({name, " zero"}, 64'(z), 64'(exp == 64'h0));
    @(negedge clk);
    valid_s = 1'b0;
  endtask

  task automatic run_shift(input int w, input logic [4:0] op,
      input logic [63:0] a, input logic [63:0] b,
      input logic [63:0] exp_r, input int exp_l,
      input string name);
    logic [63:0] r;
    logic rdy, z, bsy;
    int lat;
    bit busy_bad;
    @(negedge clk);
    a_s = a; b_s = b; ctrl_s = op; valid_s = 1'b1;
    lat = -1;
    busy_bad = 1'b0;
    for (int c = 0; c < 200; c++) begin
      #1;
      sample(w, r, rdy, z, bsy);
      if (bsy !== (!BARREL && c >= 1)) busy_bad = 1'b1;
      if (rdy === 1'b1) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    chk({name, " latency"}, 64'(lat), 64'(exp_l));
    chk({name, " result"}, r, exp_r);
    chk({name, " busy"}, 64'(busy_bad), 64'd0);
    @(negedge clk);
    #1;
    sample(w, r, rdy, z, bsy);
    chk({name, " one-shot"}, 64'(rdy), 64'(BARREL));
    @(negedge clk);
    valid_s = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [63:0] r;
    logic rdy, z, bsy;

    resetn = 1'b0; valid_s = 1'b0;
    a_s = '0; b_s = '0; ctrl_s = '0;
    repeat (3) @(negedge clk);
    #1;
    for (int w = 0; w < 3; w++) begin
      sample(w, r, rdy, z, bsy);
      chk($sformatf("reset busy%0d", w), 64'(bsy), 64'd0);
      chk($sformatf("reset ready%0d", w), 64'(rdy), 64'd0);
    end
    @(negedge clk);
    resetn = 1'b1;

    tv.push_back('{0, ALU_CTRL_SUB, 5, 7, 64'hFFFF_FFFE, "sub32"});
    tv.push_back('{0, ALU_CTRL_BLTU, 5, 7, 1, "bltu"});
    tv.push_back('{0, ALU_CTRL_BLT, 64'h8000_0000, 1, 1, "blt"});
    tv.push_back('{0, ALU_CTRL_BLTU, 64'h8000_0000, 1, 0, "bltu2"});
    tv.push_back('{0, ALU_CTRL_BGE, 64'h8000_0000, 1, 0, "bge"});
    tv.push_back('{0, ALU_CTRL_BGEU, 5, 7, 0, "bgeu"});
    tv.push_back('{0, ALU_CTRL_BEQ, 9, 9, 1, "beq"});
    tv.push_back('{0, ALU_CTRL_BNE, 9, 9, 0, "bne"});
    tv.push_back('{0, ALU_CTRL_ADD, 64'hFFFF_FFFF, 1, 0, "add wrap"});
    tv.push_back('{0, ALU_CTRL_SLT, 64'h8000_0000, 1, 1, "slt"});
    tv.push_back('{0, ALU_CTRL_SLTU, 64'h8000_0000, 1, 0, "sltu"});
    tv.push_back('{0, ALU_CTRL_AND, 64'hF0F0, 64'hFF00, 64'hF000, "and"});
    tv.push_back('{0, ALU_CTRL_OR, 64'hF0F0, 64'hFF00, 64'hFFF0, "or"});
    tv.push_back('{0, ALU_CTRL_XOR, 64'hF0F0, 64'hFF00, 64'h0FF0, "xor"});
    tv.push_back('{0, ALU_CTRL_LUI, 64'h123, 64'hABCD_E000,
                   64'hABCD_E000, "lui"});
    tv.push_back('{0, ALU_CTRL_AUIPC, 64'h1000, 64'h2000,
                   64'h3000, "auipc"});
    tv.push_back('{0, 5'd31, 64'h55, 64'h66, 0, "unknown"});
    tv.push_back('{1, ALU_CTRL_SUB, 5, 7,
                   64'hFFFF_FFFF_FFFF_FFFE, "sub64"});
    tv.push_back('{1, ALU_CTRL_BLT, 64'h8000_0000, 1, 0, "blt64"});

    foreach (tv[i])
      ns_check(tv[i].w, tv[i].op, tv[i].a, tv[i].b,
               tv[i].exp, tv[i].name);

    run_shift(0, ALU_CTRL_SRA, 64'h8000_0000, 31,
              64'hFFFF_FFFF, BARREL ? 0 : 9, "sra32 s31");
    run_shift(1, ALU_CTRL_SLL, 1, 63, 64'h8000_0000_0000_0000,
              BARREL ? 0 : 64, "sll64 s63");
    run_shift(1, ALU_CTRL_SLL, 64'h1234, 0, 64'h1234,
              BARREL ? 0 : 1, "sll64 s0");
    run_shift(2, ALU_CTRL_SRL, 64'hF000_0000, 5, 64'h0780_0000,
              BARREL ? 0 : 2, "srl32 step8");
    run_shift(0, ALU_CTRL_SRA, 64'h8000_0000, 4, 64'hF800_0000,
              BARREL ? 0 : 2, "sra32 s4");

    // Abort: drop valid in cycle 3 of a 31-bit step-1 shift
    @(negedge clk);
    a_s = 64'h7; b_s = 31; ctrl_s = ALU_CTRL_SRL; valid_s = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    sample(1, r, rdy, z, bsy);
    chk("abort busy c2", 64'(bsy), 64'(!BARREL));
    @(negedge clk);
    valid_s = 1'b0;
    #1;
    sample(1, r, rdy, z, bsy);
    chk("abort ready c3", 64'(rdy), 64'd0);
    @(negedge clk);
    #1;
    sample(1, r, rdy, z, bsy);
    chk("abort busy c4", 64'(bsy), 64'd0);
    chk("abort ready c4", 64'(rdy), 64'd0);
    run_shift(1, ALU_CTRL_SLL, 3, 1, 6, BARREL ? 0 : 2,
              "post-abort sll");

    // Reset in the middle of a long shift
    @(negedge clk);
    a_s = 64'hFF; b_s = 40; ctrl_s = ALU_CTRL_SLL; valid_s = 1'b1;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    #1;
    sample(1, r, rdy, z, bsy);
    chk("midrst busy", 64'(bsy), 64'd0);
    chk("midrst ready", 64'(rdy), 64'(BARREL));
    valid_s = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      int w;
      logic [4:0] op;
      logic [63:0] ra, rb, ex;
      w  = int'($urandom_range(0, 2));
      op = 5'($urandom_range(0, 17));
      if ($urandom_range(0, 9) == 0) op = 5'd31;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rb = ra;
      ex = ref_alu(dut_xlen(w), op, ra, rb);
      if (is_shift(op))
        run_shift(w, op, ra, rb, ex,
                  ref_lat(dut_xlen(w), dut_step(w), rb),
                  $sformatf("rnd%0d op%0d w%0d", i, op, w));
      else
        ns_check(w, op, ra, rb, ex,
                 $sformatf("rnd%0d op%0d w%0d", i, op, w));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
